// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the canonical NOP and the
// default reset address used by the fetch stage.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Keeps the PC, issues one word fetch at a time
// to instruction memory, and hands each fetched word plus its PC to the
// decoder over a valid/ready handshake. Redirects abandon the current path;
// a response already owed by memory is drained and dropped. A redirect to a
// non word-aligned target latches a sticky fault that only reset clears.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        misaligned
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc;

  logic redirect_taken;
  logic misaligned_target;
  logic response_pending;
  logic capture;

  // A redirect counts everywhere except FAULT, which only reset can leave.
  assign redirect_taken    = redirect_valid && (state != FAULT);
  assign misaligned_target = (redirect_pc[1:0] != 2'b00);

  // Memory still owes a response if it granted this cycle, or if we are
  // waiting (or draining) and the response has not shown up yet.
  assign response_pending = ((state == FETCH) && imem_gnt) ||
                            (((state == WAIT) || (state == DRAIN)) && !imem_rvalid);

  // A response in WAIT is kept only when no redirect abandons it.
  assign capture = (state == WAIT) && imem_rvalid && !redirect_taken;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a redirect overrides normal flow and, once the
  // outstanding response is gone, a latched or new fault wins over FETCH.
  always_comb begin
    state_next = state;
    if (redirect_taken) begin
      if (response_pending) begin
        state_next = DRAIN;
      end else if (misaligned_target || misaligned) begin
        state_next = FAULT;
      end else begin
        state_next = FETCH;
      end
    end else begin
      unique case (state)
        FETCH: if (imem_gnt)    state_next = WAIT;
        WAIT:  if (imem_rvalid) state_next = HOLD;
        HOLD:  if (inst_ready)  state_next = FETCH;
        DRAIN: if (imem_rvalid) state_next = misaligned ? FAULT : FETCH;
        FAULT: state_next = FAULT;
        default: state_next = FETCH;
      endcase
    end
  end

  // Memory-side outputs depend only on registered state and pc.
  always_comb begin
    imem_req  = (state == FETCH);
    imem_addr = pc;
  end

  // PC, decoder output register and sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst_valid  <= 1'b0;
      instruction <= NOP_INST;
      inst_pc     <= 32'h0000_0000;
      misaligned  <= 1'b0;
    end else begin
      if (redirect_taken) begin
        pc         <= redirect_pc;
        inst_valid <= 1'b0;
        if (misaligned_target) begin
          misaligned <= 1'b1;
        end
      end else if (capture) begin
        pc          <= pc + 32'd4;
        instruction <= imem_rdata;
        inst_pc     <= pc;
        inst_valid  <= 1'b1;
      end else if ((state == HOLD) && inst_ready) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle input/expected-output
// rows for the main instance, then a hand sequence on a second instance
// whose reset PC sits at the top of the address space.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;

  logic        imem_req,    imem_req_w;
  logic [31:0] imem_addr,   imem_addr_w;
  logic        inst_valid,  inst_valid_w;
  logic [31:0] instruction, instruction_w;
  logic [31:0] inst_pc,     inst_pc_w;
  logic        misaligned,  misaligned_w;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdr;
    logic [31:0] rdpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc), .misaligned(misaligned)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid_w), .inst_ready(inst_ready),
    .instruction(instruction_w), .inst_pc(inst_pc_w), .misaligned(misaligned_w)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Append one table row.
  task automatic addVec(input logic r, input logic g, input logic rv,
                        input logic [31:0] rd, input logic rdr,
                        input logic [31:0] rdpc, input logic rdy,
                        input logic req, input logic [31:0] addr,
                        input logic iv, input logic [31:0] instr,
                        input logic [31:0] ipc, input logic mis);
    vec_t v;
    v.rst = r;   v.gnt = g;    v.rv = rv;  v.rdata = rd;
    v.rdr = rdr; v.rdpc = rdpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.iv = iv; v.instr = instr;
    v.ipc = ipc; v.mis = mis;
    vecs.push_back(v);
  endtask

  // Single comparison; reports and counts a failure.
  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive all DUT inputs for the coming rising edge.
  task automatic driveInputs(input logic r, input logic g, input logic rv,
                             input logic [31:0] rd, input logic rdr,
                             input logic [31:0] rdpc, input logic rdy);
    rst = r; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    redirect_valid = rdr; redirect_pc = rdpc; inst_ready = rdy;
  endtask

  // On the falling edge: check the main instance, then drive this row.
  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    checkOutput("imem_req",    idx, {31'd0, imem_req},   {31'd0, v.req});
    checkOutput("imem_addr",   idx, imem_addr,           v.addr);
    checkOutput("inst_valid",  idx, {31'd0, inst_valid}, {31'd0, v.iv});
    checkOutput("instruction", idx, instruction,         v.instr);
    checkOutput("inst_pc",     idx, inst_pc,             v.ipc);
    checkOutput("misaligned",  idx, {31'd0, misaligned}, {31'd0, v.mis});
    driveInputs(v.rst, v.gnt, v.rv, v.rdata, v.rdr, v.rdpc, v.rdy);
  endtask

  // Check the wrap-around instance on the falling edge.
  task automatic checkWrap(input int idx, input logic req, input logic [31:0] addr,
                           input logic iv, input logic [31:0] instr,
                           input logic [31:0] ipc);
    @(negedge clk);
    checkOutput("wrap_imem_req",    idx, {31'd0, imem_req_w},   {31'd0, req});
    checkOutput("wrap_imem_addr",   idx, imem_addr_w,           addr);
    checkOutput("wrap_inst_valid",  idx, {31'd0, inst_valid_w}, {31'd0, iv});
    checkOutput("wrap_instruction", idx, instruction_w,         instr);
    checkOutput("wrap_inst_pc",     idx, inst_pc_w,             ipc);
    checkOutput("wrap_misaligned",  idx, {31'd0, misaligned_w}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    driveInputs(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);

    //      rst gnt rv rdata         rdr rdpc          rdy  req addr          iv instr         ipc           mis
    // two back-to-back fetches, one-cycle valid pulses
    addVec(0, 1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h0000_0000, 0, NOP_INST,     32'h0,        0); // 1
    addVec(0, 0, 1, 32'h0050_0093, 0, 32'h0,         1,   0, 32'h0000_0000, 0, NOP_INST,     32'h0,        0);
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0000_0004, 1, 32'h0050_0093, 32'h0,       0);
    addVec(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0004, 0, 32'h0050_0093, 32'h0,       0);
    addVec(0, 0, 1, 32'h00A0_0113, 0, 32'h0,         1,   0, 32'h0000_0004, 0, 32'h0050_0093, 32'h0,       0); // 5
    // decoder stalls five cycles in HOLD; a stray rvalid is ignored
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0008, 1, 32'h00A0_0113, 32'h4,       0);
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0008, 1, 32'h00A0_0113, 32'h4,       0);
    addVec(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,         0,   0, 32'h0000_0008, 1, 32'h00A0_0113, 32'h4,       0);
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0008, 1, 32'h00A0_0113, 32'h4,       0);
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0008, 1, 32'h00A0_0113, 32'h4,       0); // 10
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0000_0008, 1, 32'h00A0_0113, 32'h4,       0);
    addVec(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0008, 0, 32'h00A0_0113, 32'h4,       0);
    // redirect in WAIT, stale response drained two cycles later
    addVec(0, 0, 0, 32'h0,         1, 32'h0000_0100, 0,   0, 32'h0000_0008, 0, 32'h00A0_0113, 32'h4,       0);
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0100, 0, 32'h00A0_0113, 32'h4,       0);
    addVec(0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,         0,   0, 32'h0000_0100, 0, 32'h00A0_0113, 32'h4,       0); // 15
    addVec(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0100, 0, 32'h00A0_0113, 32'h4,       0);
    addVec(0, 0, 1, 32'h0000_0033, 0, 32'h0,         0,   0, 32'h0000_0100, 0, 32'h00A0_0113, 32'h4,       0);
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0000_0104, 1, 32'h0000_0033, 32'h100,     0);
    addVec(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0104, 0, 32'h0000_0033, 32'h100,     0);
    // redirect together with rvalid in WAIT: data dropped, no drain
    addVec(0, 0, 1, 32'h1111_1111, 1, 32'h0000_0200, 0,   0, 32'h0000_0104, 0, 32'h0000_0033, 32'h100,     0); // 20
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0200, 0, 32'h0000_0033, 32'h100,     0);
    // redirect in FETCH before grant retargets the address
    addVec(0, 0, 0, 32'h0,         1, 32'h0000_0240, 0,   1, 32'h0000_0200, 0, 32'h0000_0033, 32'h100,     0);
    addVec(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0240, 0, 32'h0000_0033, 32'h100,     0);
    addVec(0, 0, 1, 32'h0020_0193, 0, 32'h0,         0,   0, 32'h0000_0240, 0, 32'h0000_0033, 32'h100,     0);
    // redirect in HOLD with a simultaneous accept
    addVec(0, 0, 0, 32'h0,         1, 32'h0000_0300, 1,   0, 32'h0000_0244, 1, 32'h0020_0193, 32'h240,     0); // 25
    // redirect in FETCH with grant goes to DRAIN; a second redirect in DRAIN
    addVec(0, 1, 0, 32'h0,         1, 32'h0000_0400, 0,   1, 32'h0000_0300, 0, 32'h0020_0193, 32'h240,     0);
    addVec(0, 0, 0, 32'h0,         1, 32'h0000_0480, 0,   0, 32'h0000_0400, 0, 32'h0020_0193, 32'h240,     0);
    addVec(0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,         0,   0, 32'h0000_0480, 0, 32'h0020_0193, 32'h240,     0);
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0480, 0, 32'h0020_0193, 32'h240,     0);
    // misaligned redirect with nothing pending goes straight to FAULT
    addVec(0, 0, 0, 32'h0,         1, 32'h0000_0102, 0,   1, 32'h0000_0480, 0, 32'h0020_0193, 32'h240,     0); // 30
    addVec(0, 1, 1, 32'h0,         1, 32'h0000_0300, 1,   0, 32'h0000_0102, 0, 32'h0020_0193, 32'h240,     1);
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0102, 0, 32'h0020_0193, 32'h240,     1);
    addVec(1, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0102, 0, 32'h0020_0193, 32'h240,     1);
    // after reset: misaligned redirect while a response is pending
    addVec(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0000, 0, NOP_INST,     32'h0,        0);
    addVec(0, 0, 0, 32'h0,         1, 32'h0000_0006, 0,   0, 32'h0000_0000, 0, NOP_INST,     32'h0,        0); // 35
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0006, 0, NOP_INST,     32'h0,        1);
    addVec(0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,         0,   0, 32'h0000_0006, 0, NOP_INST,     32'h0,        1);
    addVec(0, 1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0006, 0, NOP_INST,     32'h0,        1);
    addVec(1, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0000_0006, 0, NOP_INST,     32'h0,        1);
    addVec(0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0000_0000, 0, NOP_INST,     32'h0,        0); // 40

    foreach (vecs[i]) applyStimulus(i + 1, vecs[i]);

    // Wrap-around instance: fetch at 0xFFFFFFFC, then at 0x00000000.
    checkWrap(100, 1'b1, 32'hFFFF_FFFC, 1'b0, NOP_INST, 32'h0);
    driveInputs(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkWrap(101, 1'b0, 32'hFFFF_FFFC, 1'b0, NOP_INST, 32'h0);
    driveInputs(1'b0, 1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
    checkWrap(102, 1'b0, 32'h0000_0000, 1'b1, 32'h0050_0093, 32'hFFFF_FFFC);
    driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkWrap(103, 1'b1, 32'h0000_0000, 1'b0, 32'h0050_0093, 32'hFFFF_FFFC);
    driveInputs(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    driveInputs(1'b0, 1'b0, 1'b1, 32'h00A0_0113, 1'b0, 32'h0, 1'b0);
    checkWrap(105, 1'b0, 32'h0000_0004, 1'b1, 32'h00A0_0113, 32'h0000_0000);
    driveInputs(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage, directly upstream of the decoder. Holds the program counter and fetches one 32-bit word per instruction from instruction memory over a request/grant/response interface. Presents the fetched word plus its PC to the decoder through a valid/ready handshake. Accepts redirects (taken branch, JAL) from control and discards any response still in flight for the abandoned path.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch byte address (always equals pc).
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid this cycle.
- imem_rdata  in  32  read data.
- redirect_valid  in  1  control redirects fetch this cycle.
- redirect_pc  in  32  redirect target byte address.
- inst_valid  out  1  instruction and inst_pc valid for the decoder.
- inst_ready  in  1  decoder consumes the instruction this cycle.
- instruction  out  32  fetched instruction word.
- inst_pc  out  32  byte address of instruction.
- misaligned  out  1  sticky fault: redirect target not word-aligned.

## Operation
- At most one outstanding memory request. Priority per cycle: rst > redirect > normal flow.
- States: FETCH, WAIT, HOLD, DRAIN, FAULT.
- FETCH: imem_req=1, imem_addr=pc. On imem_gnt, go to WAIT.
- WAIT: on imem_rvalid, capture instruction<=imem_rdata and inst_pc<=pc; set inst_valid<=1; pc<=pc+4; go to HOLD.
- HOLD: inst_valid=1. On inst_ready, clear inst_valid and go to FETCH.
- Redirect in any state except FAULT:
  - pc<=redirect_pc and inst_valid<=0. A simultaneous inst_ready completes the handshake; the instruction counts as consumed.
  - From WAIT without imem_rvalid, or from FETCH with imem_gnt, go to DRAIN.
  - From WAIT with imem_rvalid in the same cycle, discard the data and go to FETCH.
  - Otherwise go to FETCH.
- DRAIN: imem_req=0. Wait for imem_rvalid and discard the data. Then go to FETCH, or to FAULT if misaligned is set. A redirect while in DRAIN updates pc and stays in DRAIN.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - misaligned<=1 and pc<=redirect_pc.
  - If a response is pending (same DRAIN conditions as above), go to DRAIN, then FAULT.
  - Otherwise go directly to FAULT.
- FAULT: imem_req=0, inst_valid=0. Redirects are ignored. Exit only via rst.
- imem_rvalid in FETCH, HOLD or FAULT is ignored.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, inst_valid=0, instruction=32'h0000_0013 (NOP), inst_pc=0, misaligned=0.
- imem_req and imem_addr are combinational from registered state and pc only. No input-to-output combinational paths.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- Best-case sequence:
  - cycle 0: FETCH with gnt.
  - cycle 1: WAIT with rvalid.
  - cycle 2: inst_valid=1, accepted.
  - cycle 3: FETCH of pc+4.
  - Throughput is one instruction per 3 cycles.
- instruction and inst_pc hold stable while inst_valid && !inst_ready.
- In FETCH, a redirect without gnt retargets imem_addr the next cycle; the memory contract permits retargeting before grant.
- rst asserted mid-transaction returns to the reset values next cycle. Memory is reset on the same rst, so no drain is required.

## Structure
- Shared cpu_pkg holds:
  - fetch_state_t enum (FETCH, WAIT, HOLD, DRAIN, FAULT);
  - NOP_INST = 32'h0000_0013;
  - DEFAULT_RESET_PC.
- Single module, no sub-modules. Contents: one FSM, pc register, output register (instruction, inst_pc, inst_valid), misaligned flag.

## Test plan
- Reset, then memory with gnt immediate and rvalid 1 cycle later, inst_ready=1, words 0x00500093 and 0x00A00113 -> inst_pc 0x0, then 0x4; each inst_valid pulse lasts 1 cycle; imem_addr is 0x0, then 0x4.
- inst_ready held 0 for 5 cycles in HOLD -> inst_valid, instruction and inst_pc stable; no imem_req until accepted.
- Redirect to 0x100 while in WAIT; stale rdata 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never presented; next imem_addr is 0x100; inst_pc is 0x100.
- Redirect to 0x200 in the same cycle as rvalid in WAIT -> data dropped, no DRAIN, imem_req for 0x200 the next cycle.
- Redirect to 0x102 -> misaligned=1, imem_req=0 and inst_valid=0 thereafter; a later redirect to 0x300 is ignored; rst clears misaligned.
- RESET_PC=32'hFFFF_FFFC, two fetches -> inst_pc 0xFFFFFFFC, then 0x00000000.
